// File: rtl/fdiv.sv
// rtl/fdiv.sv - multi-cycle binary32 divider, radix-2 restoring mantissa datapath
// Optional FDIV_EARLY_OUT_EN: zero/denormal operands bypass DIV and finish after one edge.
module fdiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf,
    output logic        unf,
    output logic        dz,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        s_r;
    logic [7:0]  e1_r;
    logic [7:0]  e2_r;
    logic [23:0] m2_r;
    logic [25:0] q;
    logic [25:0] rem;

    logic [23:0] m1_in;
    logic [23:0] m2_in;
    logic        early;

    assign m1_in = {x1[30:23] != 8'd0, x1[22:0]};
    assign m2_in = {x2[30:23] != 8'd0, x2[22:0]};

`ifdef FDIV_EARLY_OUT_EN
    assign early = (x1[30:23] == 8'd0) || (x2[30:23] == 8'd0);
`else
    assign early = 1'b0;
`endif

    // Restoring step: the partial remainder stays below 2*m2, so 26 bits never overflow.
    logic        q_bit;
    logic [25:0] rem_diff;
    logic [25:0] rem_next;

    always_comb begin
        q_bit    = (rem >= {2'b00, m2_r});
        rem_diff = rem - {2'b00, m2_r};
        rem_next = q_bit ? {rem_diff[24:0], 1'b0} : {rem[24:0], 1'b0};
    end

    logic [23:0]       mant;
    logic              guard;
    logic              sticky;
    logic              adj;
    logic              inc;
    logic [23:0]       mant_rnd;
    logic              carry;
    logic signed [9:0] e_calc;
    logic [31:0]       y_n;
    logic              ovf_n;
    logic              unf_n;
    logic              dz_n;

    always_comb begin
        mant   = 24'd0;
        guard  = 1'b0;
        sticky = 1'b0;
        adj    = 1'b0;
        if (q[25]) begin
            mant   = q[25:2];
            guard  = q[1];
            sticky = q[0] | (rem != 26'd0);
        end else begin
            mant   = q[24:1];
            guard  = q[0];
            sticky = (rem != 26'd0);
            adj    = 1'b1;
        end
        inc      = guard & (sticky | mant[0]);
        mant_rnd = mant + {23'd0, inc};
        // A normalized mantissa has bit 23 set, so it only clears on wrap-around to 1.0.
        carry    = ~mant_rnd[23];
        e_calc   = $signed({2'b00, e1_r}) - $signed({2'b00, e2_r}) + 10'sd127
                 - $signed({9'd0, adj}) + $signed({9'd0, carry});

        y_n   = {s_r, e_calc[7:0], mant_rnd[22:0]};
        ovf_n = 1'b0;
        unf_n = 1'b0;
        dz_n  = 1'b0;
        if (e2_r == 8'd0) begin
            y_n  = {s_r, 8'hFF, 23'd0};
            dz_n = 1'b1;
        end else if (e1_r == 8'd0) begin
            y_n = 32'd0;
        end else if (e_calc >= 10'sd255) begin
            y_n   = {s_r, 8'hFF, 23'd0};
            ovf_n = 1'b1;
        end else if (e_calc <= 10'sd0) begin
            y_n   = {s_r, 31'd0};
            unf_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            cnt      <= 5'd0;
            s_r      <= 1'b0;
            e1_r     <= 8'd0;
            e2_r     <= 8'd0;
            m2_r     <= 24'd0;
            q        <= 26'd0;
            rem      <= 26'd0;
            y        <= 32'd0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            dz       <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        s_r      <= x1[31] ^ x2[31];
                        e1_r     <= x1[30:23];
                        e2_r     <= x2[30:23];
                        m2_r     <= m2_in;
                        rem      <= {2'b00, m1_in};
                        q        <= 26'd0;
                        cnt      <= 5'd0;
                        in_ready <= 1'b0;
                        state    <= early ? S_ROUND : S_DIV;
                    end
                end
                S_DIV: begin
                    q   <= {q[24:0], q_bit};
                    rem <= rem_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd25) begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    y        <= y_n;
                    ovf      <= ovf_n;
                    unf      <= unf_n;
                    dz       <= dz_n;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv.sv
// tb/tb_fdiv.sv - directed self-checking bench for fdiv
module tb_fdiv;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        ovf;
    logic        unf;
    logic        dz;
    logic        done;

    int vectors;
    int miscompares;

`ifdef FDIV_EARLY_OUT_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = 27;
`endif

    fdiv dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x1       (x1),
        .x2       (x2),
        .y        (y),
        .ovf      (ovf),
        .unf      (unf),
        .dz       (dz),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        x1 = a;
        x2 = b;
        in_valid = 1'b1;
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ey, input logic eo, input logic eu,
                       input logic ed, input int elat);
        int lat;
        start(a, b);
        wait_done(60, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_y"}, y, ey);
        check({tag, "_flags"}, {29'd0, ovf, unf, dz}, {29'd0, eo, eu, ed});
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int busy_hits;
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        x1       = 32'd0;
        x2       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", y, 32'd0);
        check("rst_flags", {28'd0, ovf, unf, dz, done}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        run("exact",      32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 27);
        run("third",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 1'b0, 27);
        run("neg_third",  32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0, 1'b0, 1'b0, 27);
        run("div_zero",   32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1'b1, LAT_Z);
        run("div_zero_n", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b0, 1'b1, LAT_Z);
        run("div_denorm", 32'h3F800000, 32'h00000001, 32'h7F800000, 1'b0, 1'b0, 1'b1, LAT_Z);
        run("zero_num",   32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1'b0, 1'b0, LAT_Z);
        run("overflow",   32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 27);
        run("overflow_n", 32'hFF000000, 32'h3E800000, 32'hFF800000, 1'b1, 1'b0, 1'b0, 27);
        run("underflow",  32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 27);
        run("max_exp",    32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, 1'b0, 27);
        run("min_exp",    32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 1'b0, 27);

        // busy period with in_valid held high and changing operands, then back-to-back
        @(negedge clk);
        x1 = 32'h40C00000;
        x2 = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        busy_hits = 0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (in_ready) busy_hits++;
        end
        check("busy_ready_low", busy_hits, 0);
        check("busy_lat", lat, 27);
        check("busy_y", y, 32'h40400000);
        check("busy_ready_done", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accepted", {31'd0, in_ready}, 32'd0);
        wait_done(60, lat);
        check("b2b_lat", lat, 27);
        check("b2b_y", y, 32'h3EAAAAAB);

        // reset at edge 10 of a division
        start(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_y", y, 32'd0);
        check("midrst_flags", {28'd0, ovf, unf, dz, done}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        wait_done(40, lat);
        check("midrst_no_done", lat, 0);
        run("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 27);

        // reset wins over in_valid at the same edge
        @(negedge clk);
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_valid_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid_y", y, 32'd0);
        wait_done(40, lat);
        check("rst_valid_no_done", lat, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
